// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl: initiator side of the integer clock divider config handshake (div/clk_init/valid/ready/done).
// Optional feature macro: CLK_DIV_CFG_SKIP_SAME_EN (skip the handshake when a request repeats the current settings).
module clk_div_cfg_ctrl #(
    parameter int DIV_VALUE_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
    input  logic                       cfg_init_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_timeout_o,
    input  logic                       err_clr_i,
    output logic [DIV_VALUE_WIDTH-1:0] div_o,
    output logic                       clk_init_o,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    input  logic                       div_done_i
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                     state_r;
    logic [DIV_VALUE_WIDTH-1:0] div_r;
    logic                       clk_init_r;
    logic                       done_r;
    logic                       err_r;
    logic [CNT_W-1:0]           cnt_r;
    logic                       same_cfg_s;

`ifdef CLK_DIV_CFG_SKIP_SAME_EN
    assign same_cfg_s = (cfg_div_i == div_r) && (cfg_init_i == clk_init_r);
`else
    assign same_cfg_s = 1'b0;
`endif

    // Request FSM; the first WAIT cycle (cnt_r == 0) ignores a stale done level from the divider.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            div_r      <= {DIV_VALUE_WIDTH{1'b0}};
            clk_init_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (err_clr_i) begin
                err_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (cfg_valid_i) begin
                        div_r      <= cfg_div_i;
                        clk_init_r <= cfg_init_i;
                        if (same_cfg_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (div_ready_i) begin
                        // A zero divide value bypasses the divider, which then never raises done.
                        if (div_r == {DIV_VALUE_WIDTH{1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end
                end
                ST_WAIT: begin
                    if ((cnt_r != {CNT_W{1'b0}}) && div_done_i) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o   = (state_r == ST_IDLE);
    assign busy_o        = (state_r != ST_IDLE);
    assign div_valid_o   = (state_r == ST_REQ);
    assign done_o        = done_r;
    assign err_timeout_o = err_r;
    assign div_o         = div_r;
    assign clk_init_o    = clk_init_r;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: directed scenarios plus randomized requests against a
// transaction-level latency model and a reactive divider model.
module tb_clk_div_cfg_ctrl;
    localparam int DVW = 32;
    localparam int T   = 16;

`ifdef CLK_DIV_CFG_SKIP_SAME_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_i;
    logic [DVW-1:0] cfg_div_i;
    logic           cfg_init_i;
    logic           cfg_valid_i;
    logic           cfg_ready_o;
    logic           busy_o;
    logic           done_o;
    logic           err_timeout_o;
    logic           err_clr_i;
    logic [DVW-1:0] div_o;
    logic           clk_init_o;
    logic           div_valid_o;
    logic           div_ready_i;
    logic           div_done_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the settings last accepted and the sticky error.
    logic [DVW-1:0] m_div;
    logic           m_init;
    logic           m_err;

    clk_div_cfg_ctrl #(.DIV_VALUE_WIDTH(DVW), .TIMEOUT_CYCLES(T)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cfg_div_i     (cfg_div_i),
        .cfg_init_i    (cfg_init_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_timeout_o (err_timeout_o),
        .err_clr_i     (err_clr_i),
        .div_o         (div_o),
        .clk_init_o    (clk_init_o),
        .div_valid_o   (div_valid_o),
        .div_ready_i   (div_ready_i),
        .div_done_i    (div_done_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One request starting from an idle negedge. The divider asserts ready after rdly valid cycles and
    // raises done wdone cycles after the handshake. With hold set, the requester keeps cfg_valid_i
    // high with (nd, ninit) while the block is busy.
    task automatic run_txn(input logic [31:0] d, input logic init, input int rdly, input int wdone,
                           input logic clr, input logic hold, input logic [31:0] nd, input logic ninit);
        int   c, hs, vcnt, n_valid, n_done, done_cyc, end_cyc, bad_hold, settle, exp_done, exp_end;
        logic skip, timeout;
        check_eq("accept_ready", 32'(cfg_ready_o), 32'd1);
        check_eq("accept_busy", 32'(busy_o), 32'd0);
        skip    = SKIP_EN && (d == m_div) && (init == m_init);
        settle  = (wdone < 2) ? 2 : wdone;
        timeout = !skip && (d != 32'd0) && (settle > T);
        exp_done = skip ? 1 : ((d == 32'd0) ? rdly + 2 : rdly + 2 + settle);
        exp_end  = timeout ? rdly + 2 + T : exp_done + 1;
        cfg_valid_i = 1'b1;
        cfg_div_i   = d;
        cfg_init_i  = init;
        err_clr_i   = clr;
        m_div  = d;
        m_init = init;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            cfg_div_i  = nd;
            cfg_init_i = ninit;
        end else begin
            cfg_valid_i = 1'b0;
        end
        c = 1; hs = -1; vcnt = 0; n_valid = 0; n_done = 0; done_cyc = -1; end_cyc = -1; bad_hold = 0;
        while (end_cyc < 0 && c <= rdly + T + 10) begin
            if (busy_o == 1'b0) begin
                end_cyc = c;
            end else begin
                if (div_o !== d || clk_init_o !== init) bad_hold++;
                if (done_o) begin
                    n_done++;
                    if (done_cyc < 0) done_cyc = c;
                end
                if (div_valid_o) begin
                    n_valid++;
                    div_ready_i = (vcnt == rdly);
                    if (vcnt == rdly) hs = c;
                    vcnt++;
                end else begin
                    div_ready_i = 1'b0;
                end
                div_done_i = (hs >= 0) && (c - hs >= wdone);
                @(negedge clk);
                c++;
            end
        end
        div_ready_i = 1'b0;
        div_done_i  = 1'b0;
        err_clr_i   = 1'b0;
        m_err = timeout ? 1'b1 : (clr ? 1'b0 : m_err);
        check_eq("valid_cycles", 32'(n_valid), skip ? 32'd0 : 32'(rdly + 1));
        check_eq("done_pulses", 32'(n_done), timeout ? 32'd0 : 32'd1);
        if (!timeout) check_eq("done_latency", 32'(done_cyc), 32'(exp_done));
        check_eq("end_cycle", 32'(end_cyc), 32'(exp_end));
        check_eq("cfg_held", 32'(bad_hold), 32'd0);
        check_eq("err_timeout", 32'(err_timeout_o), 32'(m_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cur_d, nxt_d;
        logic        cur_i, nxt_i;
        int          sel;
        rst_i = 1'b1; cfg_div_i = '0; cfg_init_i = 1'b0; cfg_valid_i = 1'b0;
        err_clr_i = 1'b0; div_ready_i = 1'b0; div_done_i = 1'b0;
        m_div = '0; m_init = 1'b0; m_err = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(cfg_ready_o), 32'd1);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_valid", 32'(div_valid_o), 32'd0);
        check_eq("rst_div", div_o, 32'd0);
        check_eq("rst_done_err", 32'({done_o, err_timeout_o, clk_init_o}), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        run_txn(32'd3, 1'b0, 0, 6, 1'b0, 1'b0, 32'd0, 1'b0);
        run_txn(32'd0, 1'b1, 0, 1, 1'b0, 1'b0, 32'd0, 1'b0);
        run_txn(32'd4, 1'b1, 0, 1, 1'b0, 1'b0, 32'd0, 1'b0);
        run_txn(32'd9, 1'b0, 1, 30, 1'b0, 1'b0, 32'd0, 1'b0);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        m_err = 1'b0;
        check_eq("err_clear", 32'(err_timeout_o), 32'd0);
        run_txn(32'd5, 1'b0, 5, 3, 1'b0, 1'b1, 32'd7, 1'b0);
        run_txn(32'd7, 1'b0, 0, 4, 1'b0, 1'b0, 32'd0, 1'b0);
        run_txn(32'd3, 1'b0, 0, 6, 1'b0, 1'b0, 32'd0, 1'b0);
        run_txn(32'd3, 1'b0, 0, 6, 1'b0, 1'b0, 32'd0, 1'b0);
        run_txn(32'd11, 1'b1, 2, 40, 1'b1, 1'b0, 32'd0, 1'b0);
        run_txn(32'd2, 1'b0, 0, 3, 1'b1, 1'b0, 32'd0, 1'b0);
        run_txn(32'd6, 1'b1, 0, 17, 1'b0, 1'b0, 32'd0, 1'b0);

        // Asynchronous reset in the middle of REQ, with the sticky error set.
        cfg_valid_i = 1'b1; cfg_div_i = 32'd5; cfg_init_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid_i = 1'b0;
        check_eq("req_valid", 32'(div_valid_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        check_eq("arst_div", div_o, 32'd0);
        check_eq("arst_valid", 32'(div_valid_o), 32'd0);
        check_eq("arst_busy", 32'(busy_o), 32'd0);
        check_eq("arst_ready", 32'(cfg_ready_o), 32'd1);
        check_eq("arst_err_init", 32'({err_timeout_o, clk_init_o}), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        m_div = '0; m_init = 1'b0; m_err = 1'b0;
        @(negedge clk);

        cur_d = 32'd0; cur_i = 1'b0;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       nxt_d = 32'd0;
                1:       nxt_d = $urandom_range(1, 15);
                2:       nxt_d = $urandom;
                default: nxt_d = cur_d;
            endcase
            nxt_i = (sel == 3) ? cur_i : 1'($urandom_range(0, 1));
            run_txn(cur_d, cur_i, $urandom_range(0, 4), $urandom_range(1, 20),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), nxt_d, nxt_i);
            cur_d = nxt_d;
            cur_i = nxt_i;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
